// File: rtl/cam_capture_ctrl.sv
// DVP camera capture controller: frames cam_vs/cam_href/cam_byte into pixels
// and emits decimated frame-buffer write beats with frame and line status.
//
// state  | meaning
// IDLE   | not capturing; waits for arm or continuous
// SYNC   | waits for cam_vs high so a partly-seen frame is skipped
// BLANK  | vertical blanking; cam_vs falling edge starts the frame
// ACTIVE | capturing lines; cam_vs rising edge ends the frame
module cam_capture_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BPP      = 2,
    parameter int XY_W     = 11,
    parameter int ADDR_W   = 19
) (
    input  logic              cam_pclk,
    input  logic              reset,
    input  logic              cam_vs,
    input  logic              cam_href,
    input  logic [7:0]        cam_byte,
    input  logic              arm,
    input  logic              continuous,
    input  logic              gray_mode,
    input  logic [1:0]        byte_sel,
    input  logic [1:0]        decim,
    output logic              wr_en,
    output logic [8*BPP-1:0]  wr_data,
    output logic [XY_W-1:0]   wr_x,
    output logic [XY_W-1:0]   wr_y,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              line_err,
    output logic              busy
);
    localparam int SX_RAW = $clog2(H_ACTIVE + 2);
    localparam int SX_W   = (SX_RAW < 2) ? 2 : SX_RAW;
    localparam int SY_RAW = $clog2(V_ACTIVE + 1);
    localparam int SY_W   = (SY_RAW < 2) ? 2 : SY_RAW;
    localparam int BC_W   = (BPP > 1) ? $clog2(BPP) : 1;
    localparam logic [SX_W-1:0] SX_LINE = SX_W'(H_ACTIVE);
    localparam logic [SX_W-1:0] SX_SAT  = SX_W'(H_ACTIVE + 1);
    localparam logic [SY_W-1:0] SY_SAT  = SY_W'(V_ACTIVE);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_BLANK, S_ACTIVE} state_t;
    state_t state, state_d;

    logic              vs_q, href_q;
    logic [1:0]        d;
    logic [SX_W-1:0]   src_x;
    logic [SY_W-1:0]   src_y;
    logic [BC_W-1:0]   byte_cnt;
    logic              line_seen;
    logic [8*BPP-1:0]  pix_acc;
    logic [ADDR_W-1:0] addr_cnt;

    logic              vs_rise, vs_fall, href_rise, href_fall;
    logic              in_line, pix_done, wr_ok;
    logic [BC_W-1:0]   byte_idx;
    logic [1:0]        dmask, sel;
    logic [8*BPP-1:0]  pix_full, pix_out;

    always_ff @(posedge cam_pclk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (arm || continuous) state_d = S_SYNC;
            S_SYNC:   if (cam_vs) state_d = S_BLANK;
            S_BLANK:  if (vs_fall) state_d = S_ACTIVE;
            S_ACTIVE: if (vs_rise) state_d = continuous ? S_BLANK : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy = (state != S_IDLE);
    end

    always_comb begin
        vs_rise   = cam_vs & ~vs_q;
        vs_fall   = ~cam_vs & vs_q;
        href_rise = cam_href & ~href_q;
        href_fall = ~cam_href & href_q;
        in_line   = (state == S_ACTIVE) && cam_href;
        // A new line always restarts at byte 0 so phase errors never carry over.
        byte_idx  = href_rise ? '0 : byte_cnt;
        pix_done  = in_line && (byte_idx == BC_LAST);
        case (d)
            2'd0:    dmask = 2'b00;
            2'd1:    dmask = 2'b01;
            default: dmask = 2'b11;
        endcase
        wr_ok = pix_done && (src_x < SX_LINE) && (src_y < SY_SAT)
                && ((src_x[1:0] & dmask) == 2'b00) && ((src_y[1:0] & dmask) == 2'b00);
        sel = (int'(byte_sel) >= BPP) ? 2'(BPP - 1) : byte_sel;
        pix_full = pix_acc;
        pix_full[7:0] = cam_byte;
        pix_out = '0;
        if (gray_mode) pix_out[7:0] = pix_full[8*(BPP-1-int'(sel)) +: 8];
        else           pix_out = pix_full;
    end

    always_ff @(posedge cam_pclk) begin
        if (reset) begin
            vs_q        <= 1'b0;
            href_q      <= 1'b0;
            d           <= '0;
            src_x       <= '0;
            src_y       <= '0;
            byte_cnt    <= '0;
            line_seen   <= 1'b0;
            pix_acc     <= '0;
            addr_cnt    <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_addr     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            line_err    <= 1'b0;
        end else begin
            vs_q        <= cam_vs;
            href_q      <= cam_href;
            wr_en       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;

            if (state == S_BLANK && vs_fall) begin
                frame_start <= 1'b1;
                d           <= (decim == 2'd0) ? 2'd0 : (decim == 2'd1) ? 2'd1 : 2'd2;
                src_x       <= '0;
                src_y       <= '0;
                byte_cnt    <= '0;
                line_seen   <= 1'b0;
                addr_cnt    <= '0;
            end

            if (in_line) begin
                line_seen <= 1'b1;
                pix_acc[8*(BPP-1-int'(byte_idx)) +: 8] <= cam_byte;
                if (pix_done) begin
                    byte_cnt <= '0;
                    if (src_x != SX_SAT) src_x <= src_x + SX_W'(1);
                    if (wr_ok) begin
                        wr_en    <= 1'b1;
                        wr_data  <= pix_out;
                        wr_x     <= XY_W'(src_x >> d);
                        wr_y     <= XY_W'(src_y >> d);
                        wr_addr  <= addr_cnt;
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                    end
                end else begin
                    byte_cnt <= byte_idx + BC_W'(1);
                end
            end

            // Line end; a leftover byte count means a partial pixel was dropped.
            if (state == S_ACTIVE && href_fall) begin
                if (line_seen) begin
                    if (src_y != SY_SAT) src_y <= src_y + SY_W'(1);
                    src_x <= '0;
                end
                line_err  <= (src_x != SX_LINE) || (byte_cnt != '0);
                byte_cnt  <= '0;
                line_seen <= 1'b0;
            end

            if (state == S_ACTIVE && vs_rise) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Parametrised camera pixel-capture controller in the `cam_pclk` domain.
- Frames the DVP-style bus (`cam_vs`, `cam_href`, `cam_byte`) into pixels and emits frame-buffer write beats (`wr_en`, data, x/y, linear address).
- Adds over the first-generation capture logic:
  - per-line byte-phase realignment;
  - multi-byte pixel assembly or single-byte (grey) extraction;
  - 1:1, 1:2 and 1:4 decimation;
  - single-shot or continuous capture;
  - frame and line status reporting.
- Sits between the camera pins and the frame buffer write port.

Parameters:
- H_ACTIVE, 640, source pixels per line
- V_ACTIVE, 480, source lines per frame
- BPP, 2, bytes per pixel (1..4)
- XY_W, 11, width of coordinate outputs
- ADDR_W, 19, width of linear write address

Ports:
- cam_pclk  in  1  capture clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cam_vs  in  1  vertical sync; high = frame blanking
- cam_href  in  1  line valid
- cam_byte  in  8  camera data byte
- arm  in  1  single-cycle request to capture from IDLE
- continuous  in  1  1 = re-arm automatically after each frame
- gray_mode  in  1  1 = keep only byte byte_sel; 0 = pack all BPP bytes
- byte_sel  in  2  byte index kept in gray_mode (values ≥ BPP clamp to BPP-1)
- decim  in  2  0 = 1:1, 1 = 1:2, 2 or 3 = 1:4
- wr_en  out  1  write strobe
- wr_data  out  8*BPP  pixel; first byte received in MSBs; gray_mode: byte in [7:0], rest 0
- wr_x  out  XY_W  destination column
- wr_y  out  XY_W  destination row
- wr_addr  out  ADDR_W  wr_y*(H_ACTIVE>>d)+wr_x
- frame_start  out  1  1-cycle pulse at start of captured frame
- frame_done  out  1  1-cycle pulse at end of captured frame
- frame_count  out  16  completed frames; wraps at 0xFFFF→0
- line_err  out  1  1-cycle pulse, line length ≠ H_ACTIVE
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE. wr_en, wr_data, wr_x, wr_y, wr_addr, frame_start, frame_done, frame_count, line_err, busy all 0. Internal counters and the previous-cycle copies of vs/href are also cleared.
- Reset mid-frame aborts the frame with no frame_done. The next capture needs a full vs high→low sequence.
- States:
  - IDLE: arm=1 or continuous=1 → SYNC.
  - SYNC: wait for cam_vs=1 sampled → BLANK. A frame already in progress when armed is skipped.
  - BLANK: cam_vs falling edge → ACTIVE. On the same edge:
    - frame_start pulses next cycle;
    - decim is latched as d (frame-stable);
    - src_y, wr_addr counters are cleared.
  - ACTIVE: cam_vs rising edge → frame_done pulses next cycle; frame_count+1; go to BLANK if continuous=1, else IDLE. Clearing continuous mid-frame completes the current frame, then goes to IDLE.
- Byte phase:
  - The byte counter is cleared on every href rising edge, so phase cannot drift across lines.
  - Bytes are counted only while href=1 in ACTIVE; href outside ACTIVE is ignored.
- Pixel completion:
  - A pixel completes when byte index BPP-1 is sampled.
  - src_x increments after each completed pixel.
  - Pixels with src_x ≥ H_ACTIVE are dropped.
- Write qualification and timing:
  - A write occurs when src_x < H_ACTIVE, src_y < V_ACTIVE, and the low d bits of both src_x and src_y are zero.
  - wr_en is asserted exactly 1 cycle after the last byte of the pixel is sampled.
  - wr_x = src_x>>d, wr_y = src_y>>d.
  - wr_addr increments by 1 per write; it is not computed by multiplication.
- Line end (href falling edge in ACTIVE):
  - If at least one byte was seen: src_y+1 and src_x←0.
  - If pixel count ≠ H_ACTIVE: line_err pulses next cycle.
  - A partial trailing pixel (byte count not a multiple of BPP) is discarded and also counts as a line error.
- Lines with src_y ≥ V_ACTIVE produce no writes. They still check line length.
- Simultaneous vs rise and href fall: line end processed first, then frame end, in the same cycle.
- arm while busy is ignored.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4, BPP=2, decim=0, gray_mode=0, continuous=0, arm; one frame with bytes 0x00..0x3F → 32 writes, wr_data 0x0001 first, 0x3E3F last; wr_addr 0..31; frame_start and frame_done each pulse once; frame_count=1; IDLE.
- Same frame with gray_mode=1, byte_sel=1 → wr_data[7:0]=0x01,0x03,…; upper byte 0.
- decim=1 → 8 writes at (0,0),(1,0)…(3,1); wr_addr 0..7. Changing decim mid-frame has no effect until the next frame.
- Line 1 carries 9 bytes (odd) → 4 pixels written, line_err pulses once, line 2 starts at byte phase 0 with wr_x=0.
- Arm mid-frame (vs low, href toggling) → no writes until after the next vs high→low. continuous=1 over 3 frames → frame_count=3 and busy held high throughout.
- Assert reset during line 2 → all outputs 0 next cycle. Arm again, then one full frame → exactly 32 writes, wr_addr restarting at 0.
